// File: rtl/sd_block_reader.sv
// sd_block_reader: SPI-mode SD single-block reader (CMD17).
// On i_start it waits for room for a whole block in the downstream FIFO.
// It then sends CMD17 for the current block address and collects R1.
// After the 0xFE data token it pushes 512 data bytes in card order.
// It consumes the 16-bit CRC, then advances the block address by one.
// Optional feature macro: SD_READ_CRC_CHECK_EN
//   defined   -> CRC16-CCITT (poly 0x1021, init 0) is computed over the 4096
//                data bits; a received-CRC mismatch ends the read in ERROR.
//   undefined -> the CRC bits are consumed and discarded; no CRC logic exists.
module sd_block_reader #(
  parameter logic [31:0] START_ADDR    = 32'h00F0_0000,
  parameter logic [7:0]  R1_TIMEOUT    = 8'h50,
  parameter logic [15:0] TOKEN_TIMEOUT = 16'd4096
) (
  input  logic        i_s_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        MISO,
  output logic        MOSI,
  input  logic [9:0]  i_10_fifo_space,
  output logic        o_fifo_push,
  output logic [7:0]  o_8_fifo_data_in,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_32_addr
);

  // Last allowed clock index (count starts at 0) for each response wait.
  localparam logic [15:0] R1_LAST    = {8'h00, R1_TIMEOUT} - 16'd1;
  localparam logic [15:0] TOKEN_LAST = TOKEN_TIMEOUT - 16'd1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_SEND_CMD,
    ST_WAIT_R1,
    ST_WAIT_TOKEN,
    ST_READ_DATA,
    ST_READ_CRC,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] cnt_reg, cnt_next;          // bit counter of the current phase
  logic [15:0] timeout_reg, timeout_next;  // clocks spent waiting for a response
  logic [15:0] shift_reg, shift_next;      // MISO shift register (R1/token/data/CRC)
  logic [47:0] cmd_reg, cmd_next;          // outgoing CMD17 frame, MSB leaves first
  logic [31:0] addr_reg, addr_next;
  logic        push_reg, push_next;
  logic [7:0]  data_reg, data_next;
  logic        error_reg, error_next;
  logic [15:0] shift_in;
  logic        state_change;

`ifdef SD_READ_CRC_CHECK_EN
  logic [15:0] crc_reg, crc_next;
  logic        crc_fb;
`endif

  // Shift register contents including the bit being sampled this clock.
  assign shift_in     = {shift_reg[14:0], MISO};
  assign state_change = (state_next != state_reg);

  // Outputs decoded from registered state so they only move on posedge.
  assign MOSI             = (state_reg == ST_SEND_CMD) ? cmd_reg[47] : 1'b1;
  assign o_busy           = state_reg inside {ST_WAIT_SPACE, ST_SEND_CMD, ST_WAIT_R1,
                                              ST_WAIT_TOKEN, ST_READ_DATA, ST_READ_CRC};
  assign o_done           = (state_reg == ST_DONE);
  assign o_fifo_push      = push_reg;
  assign o_8_fifo_data_in = data_reg;
  assign o_error          = error_reg;
  assign o_32_addr        = addr_reg;

  // State register.
  always_ff @(posedge i_s_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: protocol sequencing and the two response timeouts.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) state_next = ST_WAIT_SPACE;
      end
      ST_WAIT_SPACE: begin
        // A whole block must fit so that no push can ever meet a full FIFO.
        if (i_10_fifo_space >= 10'd512) state_next = ST_SEND_CMD;
      end
      ST_SEND_CMD: begin
        if (cnt_reg == 12'd47) state_next = ST_WAIT_R1;
      end
      ST_WAIT_R1: begin
        if (cnt_reg == 12'd0) begin
          // Still hunting for the start bit (first 0 on MISO).
          if (MISO && (timeout_reg == R1_LAST)) state_next = ST_ERROR;
        end else if (cnt_reg == 12'd7) begin
          state_next = (shift_in[7:0] == 8'h00) ? ST_WAIT_TOKEN : ST_ERROR;
        end
      end
      ST_WAIT_TOKEN: begin
        if (shift_in[7:0] == 8'hFE) begin
          state_next = ST_READ_DATA;
        end else if (timeout_reg == TOKEN_LAST) begin
          state_next = ST_ERROR;
        end
      end
      ST_READ_DATA: begin
        if (cnt_reg == 12'd4095) state_next = ST_READ_CRC;
      end
      ST_READ_CRC: begin
        if (cnt_reg == 12'd15) begin
`ifdef SD_READ_CRC_CHECK_EN
          state_next = (shift_in == crc_reg) ? ST_DONE : ST_ERROR;
`else
          state_next = ST_DONE;
`endif
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath next values: command shifting, MISO capture, byte pushes, address.
  always_comb begin
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    shift_next   = shift_reg;
    cmd_next     = cmd_reg;
    addr_next    = addr_reg;
    push_next    = 1'b0;
    data_next    = data_reg;
    error_next   = error_reg;
`ifdef SD_READ_CRC_CHECK_EN
    crc_next     = crc_reg;
    crc_fb       = crc_reg[15] ^ MISO;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (i_start) error_next = 1'b0;
      end
      ST_WAIT_SPACE: begin
        // Keep the frame loaded so it is ready on the SEND_CMD entry clock.
        cmd_next = {8'h51, addr_reg, 8'hFF};
      end
      ST_SEND_CMD: begin
        cmd_next = {cmd_reg[46:0], 1'b1};
        cnt_next = cnt_reg + 12'd1;
      end
      ST_WAIT_R1: begin
        if (cnt_reg == 12'd0) timeout_next = timeout_reg + 16'd1;
        if ((cnt_reg != 12'd0) || !MISO) begin
          shift_next = shift_in;
          cnt_next   = cnt_reg + 12'd1;
        end
      end
      ST_WAIT_TOKEN: begin
        timeout_next = timeout_reg + 16'd1;
        shift_next   = shift_in;
      end
      ST_READ_DATA: begin
        shift_next = shift_in;
        cnt_next   = cnt_reg + 12'd1;
        // The byte is registered here and appears on the FIFO port next clock.
        if (cnt_reg[2:0] == 3'd7) begin
          push_next = 1'b1;
          data_next = shift_in[7:0];
        end
`ifdef SD_READ_CRC_CHECK_EN
        crc_next = {crc_reg[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
      end
      ST_READ_CRC: begin
        shift_next = shift_in;
        cnt_next   = cnt_reg + 12'd1;
      end
      ST_DONE: begin
        addr_next = addr_reg + 32'd1;
      end
      default: begin
      end
    endcase
    if (state_next == ST_ERROR) error_next = 1'b1;
    // Every phase starts with clean counters and an empty shift register.
    if (state_change) begin
      cnt_next     = 12'd0;
      timeout_next = 16'd0;
      shift_next   = 16'd0;
    end
`ifdef SD_READ_CRC_CHECK_EN
    if (state_change && (state_next == ST_READ_DATA)) crc_next = 16'h0000;
`endif
  end

  // Datapath registers; reset aborts any read in progress without pushes.
  always_ff @(posedge i_s_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_reg     <= 12'd0;
      timeout_reg <= 16'd0;
      shift_reg   <= 16'd0;
      cmd_reg     <= 48'hFFFF_FFFF_FFFF;
      addr_reg    <= START_ADDR;
      push_reg    <= 1'b0;
      data_reg    <= 8'h00;
      error_reg   <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
      shift_reg   <= shift_next;
      cmd_reg     <= cmd_next;
      addr_reg    <= addr_next;
      push_reg    <= push_next;
      data_reg    <= data_next;
      error_reg   <= error_next;
    end
  end

`ifdef SD_READ_CRC_CHECK_EN
  // Running CRC over the data bits, checked against the received CRC.
  always_ff @(posedge i_s_clk or posedge i_reset) begin
    if (i_reset) begin
      crc_reg <= 16'h0000;
    end else begin
      crc_reg <= crc_next;
    end
  end
`endif

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: a behavioural SD card answers CMD17 from
// per-run settings. The expected FIFO contents, outcome and address come
// from a simple transaction-level model of one block read.
`timescale 1ns/1ps
module tb_sd_block_reader;

  localparam logic [31:0] START_ADDR = 32'h00F0_0000;
  localparam int R1_TO  = 'h50;
  localparam int TOK_TO = 4096;
`ifdef SD_READ_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        miso = 1'b1;
  logic        mosi;
  logic [9:0]  space = 10'd1023;
  logic        push;
  logic [7:0]  fdata;
  logic        busy, done, err;
  logic [31:0] addr;

  sd_block_reader dut (
    .i_s_clk          (clk),
    .i_reset          (rst),
    .i_start          (start),
    .MISO             (miso),
    .MOSI             (mosi),
    .i_10_fifo_space  (space),
    .o_fifo_push      (push),
    .o_8_fifo_data_in (fdata),
    .o_busy           (busy),
    .o_done           (done),
    .o_error          (err),
    .o_32_addr        (addr)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO-side observer: records every pushed byte and every done pulse.
  logic [7:0] got_q[$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (push) got_q.push_back(fdata);
    if (done) done_cnt++;
  end

  logic [7:0]  data_arr [512];
  logic [31:0] addr_model;
  bit          miso_q[$];

  task automatic push_ones(input int n);
    for (int k = 0; k < n; k++) miso_q.push_back(1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) miso_q.push_back(b[k]);
  endtask

  // One block read. r1_delay/tok_delay < 0 means the card never answers.
  task automatic run_block(input string tag, input logic [7:0] r1, input int r1_delay,
                           input int tok_delay, input bit crc_flip, input int data_mode,
                           input logic [9:0] sp, input int hold, input int reset_at);
    logic [15:0] crc;
    logic [47:0] cmd;
    logic [7:0]  cur;
    bit          fb, saw_done, saw_err, found, r1_ok, tok_ok, exp_err;
    int          elapsed, mosi_bad, busy_bad, bad, exp_pushes, lo, snap;

    for (int i = 0; i < 512; i++)
      data_arr[i] = (data_mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
    crc = 16'h0000;
    for (int i = 0; i < 512; i++) begin
      cur = data_arr[i];
      for (int k = 7; k >= 0; k--) begin
        fb  = crc[15] ^ cur[k];
        crc = {crc[14:0], 1'b0};
        if (fb) crc = crc ^ 16'h1021;
      end
    end
    if (crc_flip) crc = crc ^ 16'h0001;

    miso_q.delete();
    if (r1_delay >= 0) begin
      push_ones(r1_delay);
      push_byte(r1);
      if (r1 == 8'h00 && tok_delay >= 0) begin
        push_ones(tok_delay);
        push_byte(8'hFE);
        for (int i = 0; i < 512; i++) push_byte(data_arr[i]);
        push_byte(crc[15:8]);
        push_byte(crc[7:0]);
      end
    end
    r1_ok      = (r1_delay >= 0) && (r1 == 8'h00);
    tok_ok     = r1_ok && (tok_delay >= 0);
    exp_pushes = tok_ok ? 512 : 0;
    exp_err    = !tok_ok || (crc_flip && CRC_EN);

    got_q.delete();
    done_cnt = 0;
    space    = sp;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_eq({tag, ":err_clr"}, err, 1'b0);
    check_eq({tag, ":busy_on"}, busy, 1'b1);

    mosi_bad = 0;
    busy_bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (mosi !== 1'b1) mosi_bad++;
      if (busy !== 1'b1) busy_bad++;
    end
    if (hold > 0) begin
      check_eq({tag, ":mosi_hold"}, mosi_bad, 0);
      check_eq({tag, ":busy_hold"}, busy_bad, 0);
      space = 10'd600;
    end

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (mosi === 1'b0) found = 1'b1;
    end
    check_eq({tag, ":cmd_start"}, found, 1'b1);
    if (!found) return;
    cmd[47] = mosi;
    for (int k = 46; k >= 0; k--) begin
      @(negedge clk);
      cmd[k] = mosi;
    end
    check_eq({tag, ":cmd"}, cmd, {8'h51, addr_model, 8'hFF});

    elapsed  = 0;
    saw_done = 1'b0;
    saw_err  = 1'b0;
    mosi_bad = 0;
    while (!saw_done && !saw_err && elapsed < 12000) begin
      @(negedge clk);
      elapsed++;
      if (reset_at > 0 && elapsed == reset_at) begin
        rst = 1'b1;
        @(negedge clk);
        snap = got_q.size();
        rst  = 1'b0;
        miso = 1'b1;
        miso_q.delete();
        repeat (20) @(negedge clk);
        check_eq({tag, ":no_push_after_rst"}, got_q.size(), snap);
        check_eq({tag, ":busy_rst"}, busy, 1'b0);
        check_eq({tag, ":mosi_rst"}, mosi, 1'b1);
        check_eq({tag, ":err_rst"}, err, 1'b0);
        check_eq({tag, ":done_rst"}, done_cnt, 0);
        addr_model = START_ADDR;
        check_eq({tag, ":addr_rst"}, addr, addr_model);
        $display("run %s: reset after %0d pushes addr=%h", tag, snap, addr);
        return;
      end
      if (mosi !== 1'b1) mosi_bad++;
      saw_done = done;
      saw_err  = err;
      if (!saw_done && !saw_err) miso = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b1;
    end
    miso = 1'b1;
    miso_q.delete();
    check_eq({tag, ":finished"}, saw_done | saw_err, 1'b1);
    check_eq({tag, ":mosi_idle"}, mosi_bad, 0);

    // Timeout runs: ERROR must appear once the allowed clocks have elapsed,
    // give or take the few clocks between command end and the first sample.
    if (r1_delay < 0) begin
      lo = R1_TO;
      check_eq({tag, ":r1_timeout_clk"}, (elapsed >= lo && elapsed <= lo + 3) ? lo : elapsed, lo);
    end else if (r1_ok && tok_delay < 0) begin
      lo = TOK_TO + r1_delay + 8;
      check_eq({tag, ":tok_timeout_clk"}, (elapsed >= lo && elapsed <= lo + 3) ? lo : elapsed, lo);
    end

    repeat (3) @(negedge clk);
    check_eq({tag, ":done_pulses"}, done_cnt, exp_err ? 0 : 1);
    check_eq({tag, ":error"}, err, exp_err);
    check_eq({tag, ":pushes"}, got_q.size(), exp_pushes);
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 512; i++)
      if (got_q[i] !== data_arr[i]) bad++;
    check_eq({tag, ":bytes"}, bad, 0);
    if (!exp_err) addr_model = addr_model + 32'd1;
    check_eq({tag, ":addr"}, addr, addr_model);
    check_eq({tag, ":busy_off"}, busy, 1'b0);
    $display("run %s: r1=%h pushes=%0d done=%0d err=%0b addr=%h clk=%0d",
             tag, r1, got_q.size(), done_cnt, err, addr, elapsed);
  endtask

  int       idle_mosi_bad, idle_busy_bad;
  logic [7:0] rr1;

  initial begin
    addr_model = START_ADDR;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    done_cnt      = 0;
    idle_mosi_bad = 0;
    idle_busy_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (mosi !== 1'b1) idle_mosi_bad++;
      if (busy !== 1'b0) idle_busy_bad++;
    end
    check_eq("reset:mosi", idle_mosi_bad, 0);
    check_eq("reset:busy", idle_busy_bad, 0);
    check_eq("reset:pushes", got_q.size(), 0);
    check_eq("reset:done", done_cnt, 0);
    check_eq("reset:error", err, 1'b0);
    check_eq("reset:data", fdata, 8'h00);
    check_eq("reset:addr", addr, START_ADDR);
    $display("run reset: mosi=%b busy=%b addr=%h", mosi, busy, addr);

    run_block("spec_read",   8'h00, 10, 20, 1'b0, 0, 10'd1023, 0, 0);
    run_block("wait_space",  8'h00, 5, 8, 1'b0, 1, 10'd100, 50, 0);
    run_block("r1_error",    8'h04, 10, 20, 1'b0, 1, 10'd1023, 0, 0);
    run_block("after_error", 8'h00, 3, 3, 1'b0, 1, 10'd700, 0, 0);
    run_block("r1_timeout",  8'h00, -1, 0, 1'b0, 1, 10'd1023, 0, 0);
    run_block("tok_timeout", 8'h00, 10, -1, 1'b0, 1, 10'd1023, 0, 0);
    run_block("crc_good",    8'h00, 2, 0, 1'b0, 1, 10'd512, 0, 0);
    run_block("crc_flip",    8'h00, 7, 9, 1'b1, 1, 10'd1023, 0, 0);
    for (int n = 0; n < 3; n++) begin
      rr1 = ($urandom_range(0, 3) == 0) ? {1'b0, 7'($urandom_range(1, 127))} : 8'h00;
      run_block($sformatf("random%0d", n), rr1, $urandom_range(0, 60),
                $urandom_range(0, 100), 1'b0, 1, 10'($urandom_range(512, 1023)), 0, 0);
    end
    run_block("abort",      8'h00, 4, 4, 1'b0, 1, 10'd1023, 0, 1000);
    run_block("post_abort", 8'h00, 2, 2, 1'b0, 1, 10'd1023, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
